pwm_multi_ch: RTL and testbench
===============================

Name: pwm_multi_ch

Overview:
- Parametrised N-channel PWM generator with an Avalon-MM slave register interface.
- Successor to the fixed single-channel PWM peripherals that drive the servo outputs in the SOPC system.
- All channels share one period counter, so edges are phase-aligned.
- Per-channel duty and polarity live in shadow registers and commit glitch-free at a period boundary.

Parameters:
- NUM_CH, 4, number of PWM channels (1..12).
- CNT_W, 20, width of period/duty counter in bits (1..32).
- ADDR_W, 4, Avalon word-address width; must satisfy 4+NUM_CH <= 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid exactly 1 cycle after avs_read.
- pwm_out  out  NUM_CH  PWM outputs, bit i = channel i, registered.
- period_tick  out  1  one-cycle pulse on each counter wrap.

Behaviour:
- Reset:
  - Asynchronous reset_n=0 clears all state: counter, shadow and active registers, UPD_PEND, pwm_out=0, period_tick=0, avs_readdata=0.
  - Deassertion is used as-is (synchronised at top level).
- Register map (word addresses):
  - 0 CTRL: bit0 EN (R/W); bit1 UPD (write-1 sets UPD_PEND, reads 0).
  - 1 PERIOD_SH: [CNT_W-1:0], R/W.
  - 2 STATUS: bit0 UPD_PEND, RO; writes ignored.
  - 3 POL_SH: [NUM_CH-1:0], R/W.
  - 4+i DUTY_SH[i]: [CNT_W-1:0], R/W.
  - Unmapped addresses read 0; writes to them are ignored.
  - Write data above the field width is truncated; read data above the field width is zero-filled.
- Readback:
  - Registered: avs_readdata updates the cycle after avs_read=1 and holds otherwise.
  - Shadow registers read back the shadow value, not the active value.
- Counter:
  - cnt runs 0..PERIOD_ACT-1, +1 per clk while EN=1, and wraps to 0.
  - wrap = EN & (PERIOD_ACT != 0) & (cnt == PERIOD_ACT-1).
  - period_tick is registered and equals wrap delayed 1 cycle.
  - EN=0: cnt held at 0, period_tick=0.
  - PERIOD_ACT=0: cnt held at 0, no ticks.
- Output:
  - Next-state pwm_out[i] = (EN & PERIOD_ACT!=0 & cnt<DUTY_ACT[i]) XOR POL_ACT[i], registered (1-cycle latency from cnt).
  - DUTY_ACT=0 gives constant inactive level; DUTY_ACT >= PERIOD_ACT gives constant active level.
  - Disabled outputs sit at POL_ACT[i].
- Commit:
  - Condition: UPD_PEND=1 and (wrap=1 or EN=0).
  - Action: all *_ACT <= *_SH in one cycle; UPD_PEND cleared; cnt <= 0 on that same cycle.
  - Without UPD, shadow writes never reach the outputs.
- Simultaneous events:
  - A shadow write in the commit cycle: the commit takes the pre-write shadow value. The new value stays in shadow, and UPD_PEND stays clear unless UPD is written again.
  - A CTRL UPD write in a commit cycle: UPD_PEND remains 1 after the commit, so a second commit follows at the next wrap.
  - avs_read and avs_write to the same address in one cycle: readdata returns the pre-write value.
- EN transitions:
  - EN 1->0 mid-period: cnt resets to 0 next cycle; outputs go to their inactive level the cycle after.
  - EN 0->1: counting starts from 0.
  - Writing CTRL updates EN and UPD together.
- Reset mid-operation: all outputs go to 0 immediately (asynchronously), with no waiting for a period boundary.

Test Plan:
- Reset: assert reset_n=0 mid-run with pwm_out active -> pwm_out=0, period_tick=0, STATUS reads 0; after release, all registers read 0.
- Basic PWM: NUM_CH=4. Write PERIOD=10, DUTY0=3, DUTY1=0, DUTY2=10, DUTY3=15, POL=0, CTRL=0x3 -> ch0 high 3 of every 10 clks, ch1 constant 0, ch2 and ch3 constant 1; period_tick pulses every 10 clks; STATUS=0 after the commit.
- Glitch-free update: running PERIOD=10/DUTY0=3, write DUTY0=7 with UPD mid-period (cnt=4) -> current period unchanged, STATUS.bit0=1 until wrap; next period ch0 high 7 clks.
- Shadow without UPD: write DUTY0=5 only -> output unchanged over 3 periods; DUTY_SH0 reads back 5.
- Polarity and disable: POL=0x1, UPD, then CTRL=0 -> pwm_out[0]=1 and the others 0, cnt held, no period_tick.
- Collision: on the exact wrap cycle, write CTRL UPD while UPD_PEND=1 -> commit occurs, STATUS still 1, and a second commit occurs at the following wrap.

Source files
------------

// File: rtl/pwm_multi_ch_if.sv
// Avalon-MM slave register bus for the multi-channel PWM block.
interface pwm_multi_ch_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/pwm_multi_ch.sv
// N-channel phase-aligned PWM generator with an Avalon-MM register file.
// Period/duty/polarity are staged in shadow registers and committed together at a period boundary.
module pwm_multi_ch #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 20,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    pwm_multi_ch_if.slave     avs,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_POL    = ADDR_W'(3);

    logic              en_q;
    logic              upd_pend_q, upd_pend_d;
    logic [CNT_W-1:0]  period_sh_q, period_act_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] pol_sh_q, pol_act_q;
    logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              tick_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              wr_ctrl, wr_period, wr_pol;
    logic [NUM_CH-1:0] wr_duty;
    logic              period_nz, wrap, commit;

    always_comb begin : write_decode
        wr_ctrl   = avs.avs_write && (avs.avs_address == A_CTRL);
        wr_period = avs.avs_write && (avs.avs_address == A_PERIOD);
        wr_pol    = avs.avs_write && (avs.avs_address == A_POL);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = avs.avs_write && (avs.avs_address == ADDR_W'(4 + i));
        end
    end

    assign period_nz = (period_act_q != '0);
    assign wrap      = en_q && period_nz && (cnt_q == period_act_q - CNT_W'(1));
    // A disabled counter has no period in flight, so a pending update lands immediately.
    assign commit    = upd_pend_q && (wrap || !en_q);

    always_comb begin : next_state
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        cnt_d = cnt_q + CNT_W'(1);
        if (commit || wrap || !en_q || !period_nz) begin
            cnt_d = '0;
        end

        // A fresh UPD write wins over the clear, so a request in the commit cycle is not lost.
        upd_pend_d = upd_pend_q;
        if (commit) begin
            upd_pend_d = 1'b0;
        end
        if (wr_ctrl && avs.avs_writedata[1]) begin
            upd_pend_d = 1'b1;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (en_q && period_nz && (cnt_q < duty_act_q[i])) ^ pol_act_q[i];
        end
    end

    always_comb begin : read_mux
        rdata_d = '0;
        if (avs.avs_address == A_CTRL) begin
            rdata_d = {31'd0, en_q};
        end else if (avs.avs_address == A_PERIOD) begin
            rdata_d = 32'(period_sh_q);
        end else if (avs.avs_address == A_STATUS) begin
            rdata_d = {31'd0, upd_pend_q};
        end else if (avs.avs_address == A_POL) begin
            rdata_d = 32'(pol_sh_q);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs.avs_address == ADDR_W'(4 + i)) begin
                rdata_d = 32'(duty_sh_q[i]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q         <= 1'b0;
            upd_pend_q   <= 1'b0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            cnt_q        <= '0;
            pol_sh_q     <= '0;
            pol_act_q    <= '0;
            pwm_q        <= '0;
            tick_q       <= 1'b0;
            rdata_q      <= '0;
            // NOTE: the duty arrays are plain flops, not RAM, and must come up cleared, so they are reset.
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            upd_pend_q <= upd_pend_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            tick_q     <= wrap;

            if (wr_ctrl) begin
                en_q <= avs.avs_writedata[0];
            end
            if (wr_period) begin
                period_sh_q <= avs.avs_writedata[CNT_W-1:0];
            end
            if (wr_pol) begin
                pol_sh_q <= avs.avs_writedata[NUM_CH-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_duty[i]) begin
                    duty_sh_q[i] <= avs.avs_writedata[CNT_W-1:0];
                end
            end

            // Active set loads from the pre-edge shadow, so a same-cycle shadow write waits for the next UPD.
            if (commit) begin
                period_act_q <= period_sh_q;
                pol_act_q    <= pol_sh_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_q[i] <= duty_sh_q[i];
                end
            end

            if (avs.avs_read) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign pwm_out          = pwm_q;
    assign period_tick      = tick_q;
    assign avs.avs_readdata = rdata_q;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: scenario tasks against a period/position reference model.
module tb_pwm_multi_ch;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 20;
    localparam int ADDR_W = 4;
    localparam logic [31:0] CNT_MASK = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] POL_MASK = 32'((64'd1 << NUM_CH) - 64'd1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    pwm_multi_ch_if #(.ADDR_W(ADDR_W)) avs_if ();

    pwm_multi_ch #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (avs_if),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: k counts clocks since the enable edge; output k reflects position k-1.
    int                k;
    int                m_period;
    int                m_duty [NUM_CH];
    logic [NUM_CH-1:0] m_pol;
    bit                m_en;

    task automatic drive_idle();
        avs_if.avs_write = 1'b0;
        avs_if.avs_read  = 1'b0;
    endtask

    task automatic drive_wr(input int addr, input logic [31:0] data);
        avs_if.avs_address   = ADDR_W'(addr);
        avs_if.avs_writedata = data;
        avs_if.avs_write     = 1'b1;
        avs_if.avs_read      = 1'b0;
    endtask

    task automatic drive_rd(input int addr);
        avs_if.avs_address = ADDR_W'(addr);
        avs_if.avs_write   = 1'b0;
        avs_if.avs_read    = 1'b1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        @(negedge clk);
        drive_wr(addr, data);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic rd(input int addr, output logic [31:0] data);
        @(negedge clk);
        drive_rd(addr);
        @(negedge clk);
        drive_idle();
        data = avs_if.avs_readdata;
    endtask

    // Advance one clock and return what the model says pwm_out/period_tick must be.
    task automatic advance(output logic [NUM_CH-1:0] ep, output logic et);
        @(negedge clk);
        k++;
        if (m_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ep[i] = (((k - 1) % m_period) < m_duty[i]) ^ m_pol[i];
            end
            et = ((k % m_period) == 0);
        end else begin
            ep = m_pol;
            et = 1'b0;
        end
    endtask

    // Stop, load shadows, commit while disabled, then enable; k=0 right after the enable edge.
    task automatic configure(input int p, input int d [NUM_CH], input logic [NUM_CH-1:0] pol);
        wr(0, 32'd0);
        wr(1, 32'(p));
        wr(3, 32'(pol));
        for (int i = 0; i < NUM_CH; i++) wr(4 + i, 32'(d[i]));
        wr(0, 32'h2);
        wr(0, 32'h1);
        m_period = p;
        m_duty   = d;
        m_pol    = pol;
        m_en     = 1'b1;
        k        = 0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        drive_idle();
        avs_if.avs_address   = '0;
        avs_if.avs_writedata = '0;
        reset_n = 1'b0;
        #23 reset_n = 1'b1;
        total++;
        if (pwm_out !== '0) begin
            bad++;
            $display("FAIL reset_pwm got=%b want=0", pwm_out);
        end
        total++;
        if (period_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_tick got=%b want=0", period_tick);
        end
        for (int a = 0; a < 16; a++) begin
            rd(a, got);
            total++;
            if (got !== 32'd0) begin
                bad++;
                $display("FAIL reset_reg[%0d] got=%h want=0", a, got);
            end
        end
    endtask

    task automatic test_basic_pwm();
        int d [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic et;
        logic [31:0] got;
        d = '{3, 0, 10, 15};
        configure(10, d, '0);
        repeat (30) begin
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL basic k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
        end
        rd(2, got);
        total++;
        if (got !== 32'd0) begin
            bad++;
            $display("FAIL basic_status got=%h want=0", got);
        end
    endtask

    task automatic test_glitch_free();
        int d [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic et;
        d = '{3, 0, 10, 15};
        configure(10, d, '0);
        repeat (30) begin
            case (k)
                4:       drive_wr(4, 32'd7);
                5:       drive_wr(0, 32'h3);
                6, 10:   drive_rd(2);
                default: drive_idle();
            endcase
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL glitch k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
            if (k == 7) begin
                total++;
                if (avs_if.avs_readdata !== 32'd1) begin
                    bad++;
                    $display("FAIL glitch_pending got=%h want=1", avs_if.avs_readdata);
                end
            end
            if (k == 10) m_duty[0] = 7;
            if (k == 11) begin
                total++;
                if (avs_if.avs_readdata !== 32'd0) begin
                    bad++;
                    $display("FAIL glitch_cleared got=%h want=0", avs_if.avs_readdata);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_shadow_no_upd();
        int d [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic et;
        d = '{3, 0, 10, 15};
        configure(10, d, '0);
        repeat (35) begin
            case (k)
                2:       drive_wr(4, 32'd5);
                33:      drive_rd(4);
                default: drive_idle();
            endcase
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL shadow k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
            if (k == 34) begin
                total++;
                if (avs_if.avs_readdata !== 32'd5) begin
                    bad++;
                    $display("FAIL shadow_readback got=%h want=5", avs_if.avs_readdata);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_pol_disable();
        int d [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic et;
        d = '{3, 0, 10, 15};
        configure(10, d, '0);
        repeat (25) begin
            case (k)
                2:       drive_wr(3, 32'h1);
                3:       drive_wr(0, 32'h0);
                5:       drive_wr(0, 32'h2);
                default: drive_idle();
            endcase
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL pol_disable k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
            if (k == 4) m_en = 1'b0;
            if (k == 7) m_pol = 4'b0001;
        end
        drive_idle();
        // Re-enable: the held counter must restart from position 0.
        wr(0, 32'h1);
        m_en = 1'b1;
        k    = 0;
        repeat (20) begin
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL reenable k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
        end
    endtask

    task automatic test_collision();
        int d [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic et;
        d = '{3, 0, 10, 15};
        configure(10, d, '0);
        repeat (40) begin
            case (k)
                1, 9:    drive_wr(0, 32'h3);
                3:       drive_wr(4, 32'd5);
                10, 20:  drive_rd(2);
                12:      drive_wr(4, 32'd2);
                default: drive_idle();
            endcase
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL collision k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
            if (k == 10) m_duty[0] = 5;
            if (k == 20) m_duty[0] = 2;
            if (k == 11) begin
                total++;
                if (avs_if.avs_readdata !== 32'd1) begin
                    bad++;
                    $display("FAIL collision_still_pending got=%h want=1", avs_if.avs_readdata);
                end
            end
            if (k == 21) begin
                total++;
                if (avs_if.avs_readdata !== 32'd0) begin
                    bad++;
                    $display("FAIL collision_second_commit got=%h want=0", avs_if.avs_readdata);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_readback();
        logic [31:0] v, got;
        logic [31:0] dv [NUM_CH];
        v = $urandom;
        wr(1, v);
        rd(1, got);
        total++;
        if (got !== (v & CNT_MASK)) begin
            bad++;
            $display("FAIL rb_period got=%h want=%h", got, v & CNT_MASK);
        end
        v = $urandom;
        wr(3, v);
        rd(3, got);
        total++;
        if (got !== (v & POL_MASK)) begin
            bad++;
            $display("FAIL rb_pol got=%h want=%h", got, v & POL_MASK);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            dv[i] = $urandom;
            wr(4 + i, dv[i]);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            rd(4 + i, got);
            total++;
            if (got !== (dv[i] & CNT_MASK)) begin
                bad++;
                $display("FAIL rb_duty[%0d] got=%h want=%h", i, got, dv[i] & CNT_MASK);
            end
        end
        wr(0, 32'hFFFF_FFFD);
        rd(0, got);
        total++;
        if (got !== 32'd1) begin
            bad++;
            $display("FAIL rb_ctrl_en got=%h want=1", got);
        end
        wr(0, 32'd0);
        wr(2, 32'hFFFF_FFFF);
        rd(2, got);
        total++;
        if (got !== 32'd0) begin
            bad++;
            $display("FAIL rb_status_ro got=%h want=0", got);
        end
        for (int a = 4 + NUM_CH; a < 16; a++) begin
            wr(a, $urandom);
            rd(a, got);
            total++;
            if (got !== 32'd0) begin
                bad++;
                $display("FAIL rb_unmapped[%0d] got=%h want=0", a, got);
            end
        end
        // Read and write of the same register in one cycle returns the old value.
        v = $urandom;
        @(negedge clk);
        drive_wr(4, v);
        avs_if.avs_read = 1'b1;
        @(negedge clk);
        drive_idle();
        total++;
        if (avs_if.avs_readdata !== (dv[0] & CNT_MASK)) begin
            bad++;
            $display("FAIL rb_rdwr got=%h want=%h", avs_if.avs_readdata, dv[0] & CNT_MASK);
        end
        rd(4, got);
        total++;
        if (got !== (v & CNT_MASK)) begin
            bad++;
            $display("FAIL rb_rdwr_new got=%h want=%h", got, v & CNT_MASK);
        end
        avs_if.avs_address = ADDR_W'(1);
        repeat (3) @(negedge clk);
        total++;
        if (avs_if.avs_readdata !== (v & CNT_MASK)) begin
            bad++;
            $display("FAIL rb_hold got=%h want=%h", avs_if.avs_readdata, v & CNT_MASK);
        end
    endtask

    task automatic test_random();
        int d [NUM_CH];
        int p;
        logic [NUM_CH-1:0] pol, ep;
        logic et;
        for (int it = 0; it < 8; it++) begin
            p = int'($urandom_range(1, 20));
            for (int i = 0; i < NUM_CH; i++) d[i] = int'($urandom_range(0, p + 2));
            pol = NUM_CH'($urandom);
            configure(p, d, pol);
            repeat (3 * p + 3) begin
                advance(ep, et);
                total++;
                if ({pwm_out, period_tick} !== {ep, et}) begin
                    bad++;
                    $display("FAIL random it=%0d p=%0d k=%0d got=%b/%b want=%b/%b",
                             it, p, k, pwm_out, period_tick, ep, et);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int d [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic et;
        logic [31:0] got;
        d = '{8, 8, 8, 8};
        configure(8, d, '0);
        repeat (5) begin
            advance(ep, et);
            total++;
            if ({pwm_out, period_tick} !== {ep, et}) begin
                bad++;
                $display("FAIL reset_mid_run k=%0d got=%b/%b want=%b/%b", k, pwm_out, period_tick, ep, et);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (pwm_out !== '0) begin
            bad++;
            $display("FAIL reset_mid_pwm got=%b want=0", pwm_out);
        end
        total++;
        if (period_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_tick got=%b want=0", period_tick);
        end
        total++;
        if (avs_if.avs_readdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_rdata got=%h want=0", avs_if.avs_readdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(a, got);
            total++;
            if (got !== 32'd0) begin
                bad++;
                $display("FAIL reset_mid_reg[%0d] got=%h want=0", a, got);
            end
        end
        total++;
        if (pwm_out !== '0) begin
            bad++;
            $display("FAIL reset_mid_after got=%b want=0", pwm_out);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_pwm();
        test_glitch_free();
        test_shadow_no_upd();
        test_pol_disable();
        test_collision();
        test_readback();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
